ir_cmd_sequencer: RTL and testbench
===================================

# ir_cmd_sequencer

Controller between the NEC IR receiver and the snake game logic. It watches the receiver's 32-bit `word`, validates the frame, and maps the command byte to a 2-bit direction. It queues accepted directions in a small FIFO behind a valid/ready handshake, then drives the receiver's reset to clear `word` and re-arm it for the next frame.

## Interface
- `ADDR`, 8'h20: required NEC address byte.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `RST_CYC`, 2: cycles `rx_rst_n` is held low per re-arm; ≥1.
- `CLR_TO`, 16: cycles to wait for `word_in`==0 after re-arm before re-arming again.

Ports:
- `nec_clk` in 1: single clock, shared with the receiver.
- `reset_n` in 1: asynchronous, active-low reset.
- `word_in` in 32: receiver `word` output.
- `rx_rst_n` out 1: receiver reset_n; registered.
- `dir` out 2: head direction: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT.
- `dir_valid` out 1: FIFO non-empty.
- `dir_ready` in 1: consumer accepts head.
- `drop_cnt` out 8: saturating count of rejected frames.
- `stuck` out 1: sticky; set on any CLR_TO timeout.

## Operation
- Frame fields: addr=[31:24], naddr=[23:16], cmd=[15:8], ncmd=[7:0].
- A frame is valid when all of these hold:
  - naddr == ~addr
  - ncmd == ~cmd
  - addr == ADDR
  - cmd ∈ {6A→UP, EA→DOWN, 1A→LEFT, 9A→RIGHT}
- FSM states:
  - IDLE: if `word_in`≠0, latch it into `cap` and go to CHECK.
  - CHECK (one cycle): push if the frame is valid, the FIFO is not full, and the filter passes (Configuration). Otherwise `drop_cnt`++ (saturates at 255). Go to RX_RST.
  - RX_RST: `rx_rst_n`=0 for exactly RST_CYC cycles, then go to WAIT_CLEAR.
  - WAIT_CLEAR: if `word_in`==0, go to IDLE. After CLR_TO cycles without that, set `stuck` and go to RX_RST.
- FIFO:
  - Pointers carry an extra wrap bit.
  - Full/empty are evaluated on pre-edge state.
  - A push when full is blocked even if a pop occurs the same cycle; the frame is counted in `drop_cnt`.
  - Simultaneous push and pop when non-full and non-empty: both take effect, occupancy unchanged.
  - Pop when `dir_valid & dir_ready`; `dir` is held stable while `dir_valid & ~dir_ready`.
- Reset (async assert; deassert sampled on `nec_clk`):
  - State goes to IDLE, FIFO empties, `cap`=0.
  - Outputs: `dir`=0, `dir_valid`=0, `drop_cnt`=0, `stuck`=0.
  - `rx_rst_n`=0 while `reset_n`=0 and 1 from the first edge after release.
  - A reset asserted mid-frame or mid-re-arm abandons the frame without counting it.

## Timing
- Latency from `word_in` nonzero at edge N:
  - `cap` loads at N.
  - The FIFO write occurs at N+1.
  - `dir_valid` rises after N+1, i.e. visible in cycle N+2, when the FIFO was empty.
- `rx_rst_n` goes low from edge N+2 for RST_CYC cycles.
- The receiver clears `word` at the first `nec_clk` edge seen with `rx_rst_n` low. In normal operation WAIT_CLEAR exits on its first cycle.
- Minimum frame-to-frame turnaround is 3+RST_CYC cycles, far below the NEC frame period.
- `word_in` changes during CHECK or RX_RST are ignored; `cap` is the decision source.
- `dir_valid` depends only on FIFO state, with no combinational path from `dir_ready`.

## Configuration
- `IR_REVERSE_FILTER_EN` defined:
  - A 3-bit register holds the last pushed direction plus a valid flag; it is cleared on reset.
  - In CHECK, a direction opposite the last pushed one is rejected and counted in `drop_cnt`. Opposite pairs are UP/DOWN and LEFT/RIGHT.
  - The register updates on every push, including the first after reset.
- `IR_REVERSE_FILTER_EN` undefined:
  - No filter register exists.
  - All valid, mapped frames are pushed when the FIFO has space.

## Test plan
- Reset then `word_in`=20DF6A95 held until `rx_rst_n` low:
  - `dir_valid`=1 and `dir`=0 two cycles after capture.
  - `rx_rst_n` low exactly RST_CYC cycles; `drop_cnt`=0.
- `word_in`=20DF6A94 (bad ncmd), then 21DE6A95 (wrong addr):
  - No push; `drop_cnt`=2.
  - `rx_rst_n` pulsed both times.
- `dir_ready`=0, five valid frames UP, LEFT, DOWN, RIGHT, UP (filter off):
  - FIFO holds UP, LEFT, DOWN, RIGHT; fifth dropped; `drop_cnt`=1.
  - Raising `dir_ready` pops them in order.
- Full FIFO, with a pop and a CHECK push in the same cycle:
  - Push blocked; occupancy DEPTH-1; `drop_cnt` increments.
- `word_in` held at 20DF9A65 after re-arm (receiver not responding):
  - `stuck`=1 after CLR_TO cycles.
  - `rx_rst_n` pulses again; no second push.
- Filter on, frames RIGHT then LEFT:
  - LEFT dropped; `drop_cnt`=1.
  - A following UP is pushed.
- `reset_n` asserted during RX_RST:
  - All outputs return to reset values immediately.

Source files
------------

// File: rtl/ir_cmd_sequencer.sv
// ir_cmd_sequencer: validates NEC frames from the IR receiver, maps the command
// byte to a snake direction, queues it in a small FIFO behind a valid/ready
// handshake, and re-arms the receiver by pulsing its reset.
// Optional macro IR_REVERSE_FILTER_EN: reject a direction opposite the last
// pushed one (UP/DOWN, LEFT/RIGHT).
module ir_cmd_sequencer #(
  parameter logic [7:0] ADDR    = 8'h20,
  parameter int         DEPTH   = 4,
  parameter int         RST_CYC = 2,
  parameter int         CLR_TO  = 16
) (
  input  logic        nec_clk,
  input  logic        reset_n,
  input  logic [31:0] word_in,
  output logic        rx_rst_n,
  output logic [1:0]  dir,
  output logic        dir_valid,
  input  logic        dir_ready,
  output logic [7:0]  drop_cnt,
  output logic        stuck
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (RST_CYC > CLR_TO) ? RST_CYC : CLR_TO;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_TO - 1);

  typedef enum logic [1:0] {IDLE, CHECK, RX_RST, WAIT_CLEAR} state_t;

  state_t        state, nxt;
  logic [31:0]   cap;
  logic [CW-1:0] cnt;

  logic          cap_ld, push, drop, cnt_clr, cnt_inc, set_stuck;
  logic [1:0]    cmd_dir;
  logic          cmd_hit, frame_ok, filt_ok;

  // FIFO storage; pointers carry an extra wrap bit
  logic [1:0]    mem [DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          empty, full, pop;

  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dir_valid = ~empty;
  assign dir       = mem[rptr[AW-1:0]];
  assign pop       = dir_valid & dir_ready;

  // Command byte to direction; cmd_hit flags a known command
  always_comb begin
    cmd_dir = 2'd0;
    cmd_hit = 1'b1;
    case (cap[15:8])
      8'h6A:   cmd_dir = 2'd0;
      8'hEA:   cmd_dir = 2'd1;
      8'h1A:   cmd_dir = 2'd2;
      8'h9A:   cmd_dir = 2'd3;
      default: cmd_hit = 1'b0;
    endcase
  end

  assign frame_ok = cmd_hit && (cap[23:16] == ~cap[31:24]) &&
                    (cap[7:0] == ~cap[15:8]) && (cap[31:24] == ADDR);

`ifdef IR_REVERSE_FILTER_EN
  logic [1:0] last_dir;
  logic       last_vld;

  // Opposite pairs differ only in bit 0 (UP/DOWN = 0/1, LEFT/RIGHT = 2/3)
  assign filt_ok = ~(last_vld && ((cmd_dir ^ last_dir) == 2'b01));

  // Remember the most recently pushed direction
  always_ff @(posedge nec_clk or negedge reset_n) begin
    if (!reset_n) begin
      last_dir <= 2'd0;
      last_vld <= 1'b0;
    end else if (push) begin
      last_dir <= cmd_dir;
      last_vld <= 1'b1;
    end
  end
`else
  assign filt_ok = 1'b1;
`endif

  // Next-state and per-state control strobes
  always_comb begin
    nxt       = state;
    cap_ld    = 1'b0;
    push      = 1'b0;
    drop      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    set_stuck = 1'b0;
    case (state)
      IDLE: begin
        if (word_in != 32'd0) begin
          cap_ld = 1'b1;
          nxt    = CHECK;
        end
      end
      CHECK: begin
        // full is the pre-edge view: a same-cycle pop does not make room
        if (frame_ok && !full && filt_ok) push = 1'b1;
        else                              drop = 1'b1;
        cnt_clr = 1'b1;
        nxt     = RX_RST;
      end
      RX_RST: begin
        if (cnt == RST_LAST) begin
          cnt_clr = 1'b1;
          nxt     = WAIT_CLEAR;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT_CLEAR: begin
        if (word_in == 32'd0) begin
          nxt = IDLE;
        end else if (cnt == CLR_LAST) begin
          set_stuck = 1'b1;
          cnt_clr   = 1'b1;
          nxt       = RX_RST;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // State, capture register, shared cycle counter, sticky and drop counters
  always_ff @(posedge nec_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cap      <= 32'd0;
      cnt      <= '0;
      stuck    <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      state <= nxt;
      if (cap_ld)       cap <= word_in;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (set_stuck)    stuck <= 1'b1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Receiver reset is low for the cycles following each RX_RST cycle
  always_ff @(posedge nec_clk or negedge reset_n) begin
    if (!reset_n) rx_rst_n <= 1'b0;
    else          rx_rst_n <= (state != RX_RST);
  end

  // FIFO write/read pointers and storage
  always_ff @(posedge nec_clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= cmd_dir;
        wptr              <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_ir_cmd_sequencer.sv
// Directed bench for ir_cmd_sequencer: models the receiver by clearing
// word_in once rx_rst_n is seen low; checks handshake, drops, timeouts.
module tb_ir_cmd_sequencer;

  logic        nec_clk = 1'b0;
  logic        reset_n;
  logic [31:0] word_in;
  logic        rx_rst_n;
  logic [1:0]  dir;
  logic        dir_valid;
  logic        dir_ready;
  logic [7:0]  drop_cnt;
  logic        stuck;

  int n_run = 0;
  int n_bad = 0;

  localparam logic [31:0] F_UP    = 32'h20DF6A95;
  localparam logic [31:0] F_DOWN  = 32'h20DFEA15;
  localparam logic [31:0] F_LEFT  = 32'h20DF1AE5;
  localparam logic [31:0] F_RIGHT = 32'h20DF9A65;

  always #5 nec_clk = ~nec_clk;

  ir_cmd_sequencer #(.ADDR(8'h20), .DEPTH(4), .RST_CYC(2), .CLR_TO(16)) dut (
    .nec_clk   (nec_clk),
    .reset_n   (reset_n),
    .word_in   (word_in),
    .rx_rst_n  (rx_rst_n),
    .dir       (dir),
    .dir_valid (dir_valid),
    .dir_ready (dir_ready),
    .drop_cnt  (drop_cnt),
    .stuck     (stuck)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a frame at a negedge; optionally pop during CHECK; optionally
  // clear word_in like the receiver would. Returns rx_rst_n low-cycle count
  // and dir_valid/dir sampled two negedges after driving.
  task automatic send(input logic [31:0] w, input bit clr, input bit pop_chk,
                      output int lo, output logic v2, output logic [1:0] d2);
    int k;
    word_in = w;
    @(negedge nec_clk);
    if (pop_chk) dir_ready = 1'b1;
    @(negedge nec_clk);
    dir_ready = 1'b0;
    v2 = dir_valid;
    d2 = dir;
    k = 0;
    while (rx_rst_n && k < 20) begin @(negedge nec_clk); k++; end
    if (rx_rst_n) chk("rx_lo_timeout", 32'd1, 32'd0);
    lo = 0;
    while (!rx_rst_n && lo < 40) begin
      lo++;
      @(negedge nec_clk);
      if (clr) word_in = 32'd0;
    end
  endtask

  task automatic pop_one(input string tag, input logic [1:0] exp);
    chk({tag, "_v"}, {31'd0, dir_valid}, 32'd1);
    chk({tag, "_d"}, {30'd0, dir}, {30'd0, exp});
    dir_ready = 1'b1;
    @(negedge nec_clk);
    dir_ready = 1'b0;
  endtask

  initial begin
    int lo;
    int k;
    logic v2;
    logic [1:0] d2;

    reset_n   = 1'b0;
    word_in   = 32'd0;
    dir_ready = 1'b0;
    #3;
    chk("rst_rx",    {31'd0, rx_rst_n},  32'd0);
    chk("rst_valid", {31'd0, dir_valid}, 32'd0);
    chk("rst_dir",   {30'd0, dir},       32'd0);
    chk("rst_drop",  {24'd0, drop_cnt},  32'd0);
    chk("rst_stuck", {31'd0, stuck},     32'd0);
    @(negedge nec_clk);
    reset_n = 1'b1;
    @(negedge nec_clk);
    chk("rx_after_rst", {31'd0, rx_rst_n}, 32'd1);

    // First valid frame: UP
    send(F_UP, 1'b1, 1'b0, lo, v2, d2);
    chk("t1_valid", {31'd0, v2}, 32'd1);
    chk("t1_dir",   {30'd0, d2}, 32'd0);
    chk("t1_lo",    lo,          32'd2);
    chk("t1_drop",  {24'd0, drop_cnt}, 32'd0);
    pop_one("t1_pop", 2'd0);
    chk("t1_empty", {31'd0, dir_valid}, 32'd0);

    // Bad ncmd, then wrong address
    send(32'h20DF6A94, 1'b1, 1'b0, lo, v2, d2);
    chk("t2a_lo", lo, 32'd2);
    send(32'h21DE6A95, 1'b1, 1'b0, lo, v2, d2);
    chk("t2b_lo",    lo, 32'd2);
    chk("t2_drop",   {24'd0, drop_cnt},  32'd2);
    chk("t2_nopush", {31'd0, dir_valid}, 32'd0);

    // Five frames with no consumer: fifth dropped
    send(F_UP,    1'b1, 1'b0, lo, v2, d2);
    send(F_LEFT,  1'b1, 1'b0, lo, v2, d2);
    send(F_DOWN,  1'b1, 1'b0, lo, v2, d2);
    send(F_RIGHT, 1'b1, 1'b0, lo, v2, d2);
    send(F_UP,    1'b1, 1'b0, lo, v2, d2);
    chk("t3_drop", {24'd0, drop_cnt}, 32'd3);
    pop_one("t3_p0", 2'd0);
    pop_one("t3_p1", 2'd2);
    pop_one("t3_p2", 2'd1);
    pop_one("t3_p3", 2'd3);
    chk("t3_empty", {31'd0, dir_valid}, 32'd0);

    // Full FIFO, pop in the CHECK cycle: push still blocked
    send(F_UP,    1'b1, 1'b0, lo, v2, d2);
    send(F_LEFT,  1'b1, 1'b0, lo, v2, d2);
    send(F_DOWN,  1'b1, 1'b0, lo, v2, d2);
    send(F_RIGHT, 1'b1, 1'b0, lo, v2, d2);
    send(F_DOWN,  1'b1, 1'b1, lo, v2, d2);
    chk("t4_drop", {24'd0, drop_cnt}, 32'd4);
    pop_one("t4_p0", 2'd2);
    pop_one("t4_p1", 2'd1);
    pop_one("t4_p2", 2'd3);
    chk("t4_empty", {31'd0, dir_valid}, 32'd0);

    // Receiver never clears: timeout, stuck, re-arm again, single push
    send(F_RIGHT, 1'b0, 1'b0, lo, v2, d2);
    chk("t5_lo",    lo, 32'd2);
    chk("t5_stuck0", {31'd0, stuck}, 32'd0);
    k = 0;
    while (!stuck && k < 40) begin @(negedge nec_clk); k++; end
    chk("t5_stuck", {31'd0, stuck}, 32'd1);
    chk("t5_to_cyc", k, 32'd15);
    k = 0;
    while (rx_rst_n && k < 10) begin @(negedge nec_clk); k++; end
    chk("t5_rearm", {31'd0, rx_rst_n}, 32'd0);
    word_in = 32'd0;
    repeat (6) @(negedge nec_clk);
    chk("t5_rx_hi", {31'd0, rx_rst_n}, 32'd1);
    pop_one("t5_p0", 2'd3);
    chk("t5_single", {31'd0, dir_valid}, 32'd0);
    chk("t5_drop",   {24'd0, drop_cnt},  32'd4);

    // RIGHT then LEFT then UP: LEFT rejected only with the filter
    send(F_RIGHT, 1'b1, 1'b0, lo, v2, d2);
    send(F_LEFT,  1'b1, 1'b0, lo, v2, d2);
    send(F_UP,    1'b1, 1'b0, lo, v2, d2);
`ifdef IR_REVERSE_FILTER_EN
    chk("t6_drop", {24'd0, drop_cnt}, 32'd5);
    pop_one("t6_p0", 2'd3);
    pop_one("t6_p1", 2'd0);
`else
    chk("t6_drop", {24'd0, drop_cnt}, 32'd4);
    pop_one("t6_p0", 2'd3);
    pop_one("t6_p1", 2'd2);
    pop_one("t6_p2", 2'd0);
`endif
    chk("t6_empty", {31'd0, dir_valid}, 32'd0);

    // Reset during RX_RST: everything back to reset values at once
    word_in = F_UP;
    repeat (3) @(negedge nec_clk);
    chk("t7_in_rxrst", {31'd0, rx_rst_n}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("t7_rx",    {31'd0, rx_rst_n},  32'd0);
    chk("t7_valid", {31'd0, dir_valid}, 32'd0);
    chk("t7_dir",   {30'd0, dir},       32'd0);
    chk("t7_drop",  {24'd0, drop_cnt},  32'd0);
    chk("t7_stuck", {31'd0, stuck},     32'd0);
    @(negedge nec_clk);
    word_in = 32'd0;
    reset_n = 1'b1;
    @(negedge nec_clk);
    chk("t7_rx_hi", {31'd0, rx_rst_n}, 32'd1);
    send(F_LEFT, 1'b1, 1'b0, lo, v2, d2);
    chk("t7_post_v", {31'd0, v2}, 32'd1);
    chk("t7_post_d", {30'd0, d2}, 32'd2);
    chk("t7_post_drop", {24'd0, drop_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_bad);
    $finish;
  end

endmodule
